mac_rx_frame_buf: RTL
=====================

Name: mac_rx_frame_buf

Overview:
Store-and-forward commit/drop buffer between the MAC RX output and the IP layer. The MAC RX reports CRC errors and PCS cancels only on or after the last beat, so beats cannot be passed upward as they arrive. This block writes every beat of a frame into local storage and releases the frame to the IP layer only when the frame terminates cleanly. Cancelled, truncated and overflowing frames are rewound and never become visible downstream.

Parameters:
DATA_W, 16, datapath width in bits; 16, 32 or 64.
LEN_W, $clog2((DATA_W/8)+1), width of the valid-byte count (localparam).
DEPTH, 64, number of beat entries; must be a power of 2, minimum 4.
ADDR_W, $clog2(DEPTH), entry index width (localparam). Pointers are ADDR_W+1 bits wide.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_i  in  1  beat valid from MAC RX
start_i  in  1  first beat of frame; qualified by valid_i
term_i  in  1  last beat of frame; qualified by valid_i
data_i  in  DATA_W  beat payload
len_i  in  LEN_W  valid bytes in the beat
cancel_i  in  1  drop the current frame (CRC error or PCS cancel); qualified by valid_i
valid_o  out  1  committed beat available
ready_i  in  1  IP layer accepts the beat
start_o  out  1  first beat of frame
term_o  out  1  last beat of frame
data_o  out  DATA_W  beat payload
len_o  out  LEN_W  valid bytes in the beat
drop_o  out  1  one-cycle pulse when a frame is discarded

Behaviour:
- Storage: DEPTH entries, each holding {start, term, len, data}. Implemented as a flop array with combinational read.
- Pointers:
  - wr_q: next write slot.
  - commit_q: end of the last committed frame.
  - rd_q: next read slot.
  - All pointers are ADDR_W+1 bits and wrap naturally.
- full = (wr_q - rd_q) == DEPTH, computed from registered values, so it is conservative on a same-cycle read.
- Reset values: all pointers 0; FSM in IDLE; valid_o=0; drop_o=0. Storage is not reset. A reset mid-frame or mid-read loses all buffered content.
- Write FSM, states IDLE / WRITE / DISCARD:
  - IDLE:
    - valid_i & start_i & ~cancel_i & ~full: write the beat and go to WRITE. If term_i is also set, commit immediately (commit_q <= wr_q+1) and stay in IDLE.
    - valid_i & start_i with cancel_i: pulse drop_o and stay in IDLE.
    - valid_i & start_i with full: pulse drop_o and go to DISCARD.
    - Beats without start_i are ignored.
  - WRITE, priority order on a valid_i beat:
    1. cancel_i: wr_q <= commit_q, pulse drop_o, go to IDLE.
    2. start_i: the previous frame is truncated. Pulse drop_o and rewind; the new beat is written at commit_q and wr_q <= commit_q+1. Remain in WRITE, or commit it immediately if term_i is also set.
    3. full: wr_q <= commit_q, pulse drop_o, go to DISCARD.
    4. Otherwise write the beat. If term_i is set, commit_q <= wr_q+1 and go to IDLE.
  - DISCARD:
    - Ignore beats.
    - valid_i & (term_i | cancel_i): go to IDLE.
    - valid_i & start_i: handle exactly as in IDLE.
    - drop_o does not pulse again in DISCARD.
  - Cycles with valid_i=0 never change the FSM or the pointers.
- Frames longer than DEPTH beats always overflow and are dropped. Upper layers detect loss by the absence of the frame.
- Read side (first-word fall-through):
  - valid_o = (rd_q != commit_q).
  - start_o, term_o, data_o and len_o come from the entry at rd_q.
  - rd_q increments on valid_o & ready_i.
  - Outputs are held stable while valid_o & ~ready_i.
- Latency: a term beat sampled at edge T makes the frame's first beat visible on valid_o in the cycle after T, provided earlier frames have already drained.
- Simultaneous write, commit and read in the same cycle are legal and independent.
- A rewind never moves wr_q below commit_q, so committed data is never lost.
- Outputs start_o, term_o, data_o and len_o are don't-care while valid_o=0.

Optional Feature:
RX_DROP_CNT_EN: when defined, adds an output port drop_cnt_o (16 bits).
- The counter increments on every drop_o pulse and saturates at 16'hFFFF.
- It clears to 0 on reset, and also when the input drop_cnt_clr_i is high (clear takes priority over increment).
- drop_cnt_clr_i exists only when the macro is defined.
- Without the macro, neither port nor the counter exists, and drop_o is the only loss indication.

Test Plan:
- Clean frame, DATA_W=16, 5 beats with ready_i=1 and term beat len_i=1 -> valid_o first rises 1 cycle after the term edge; 5 beats out in order; start_o on beat 0; term_o on beat 4 with len_o=1; no drop_o.
- Cancel on the term beat of a 4-beat frame -> drop_o pulses once; valid_o stays 0; wr_q returns to its pre-frame value; the next clean frame is output unaltered.
- Overflow with DEPTH=8, ready_i=0, one 6-beat frame committed, then a 4-beat frame -> drop_o on the 3rd beat; the second frame is discarded until its term; raising ready_i outputs exactly the 6 committed beats.
- Truncation: start_i at beat 3 of a frame that has no term -> one drop_o pulse; only the second frame is output, with start_o on its own first beat.
- Backpressure: toggle ready_i 1,0,0,1 while reading a 3-beat frame -> data_o and len_o are held across the stalled cycles; no beat is duplicated or skipped.
- RX_DROP_CNT_EN: 3 cancelled frames, then pulse drop_cnt_clr_i, then 1 overflow -> drop_cnt_o reads 3, then 0, then 1.

Source files
------------

// File: rtl/mac_rx_frame_buf_if.sv
// Beat-stream bundle between MAC RX, the commit/drop frame buffer and the IP layer.
// The slave modport is the buffer's view; the master modport is the MAC/IP side.
interface mac_rx_frame_buf_if #(
  parameter int DATA_W = 16
);
  localparam int LEN_W = $clog2((DATA_W / 8) + 1);

  logic              valid_i;
  logic              start_i;
  logic              term_i;
  logic              cancel_i;
  logic [DATA_W-1:0] data_i;
  logic [LEN_W-1:0]  len_i;

  logic              valid_o;
  logic              ready_i;
  logic              start_o;
  logic              term_o;
  logic [DATA_W-1:0] data_o;
  logic [LEN_W-1:0]  len_o;
  logic              drop_o;

  modport slave (
    input  valid_i, start_i, term_i, cancel_i, data_i, len_i, ready_i,
    output valid_o, start_o, term_o, data_o, len_o, drop_o
  );

  modport master (
    output valid_i, start_i, term_i, cancel_i, data_i, len_i, ready_i,
    input  valid_o, start_o, term_o, data_o, len_o, drop_o
  );
endinterface

// File: rtl/mac_rx_frame_buf.sv
// Store-and-forward RX frame buffer: frames appear 1 cycle after their term beat, FWFT read held under ready_i=0;
// bad frames are rewound with a drop_o pulse. RX_DROP_CNT_EN adds a saturating drop counter (drop_cnt_o/drop_cnt_clr_i).
module mac_rx_frame_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
`ifdef RX_DROP_CNT_EN
  input  logic              drop_cnt_clr_i,
  output logic [15:0]       drop_cnt_o,
`endif
  mac_rx_frame_buf_if.slave bus
);

  localparam int LEN_W  = $clog2((DATA_W / 8) + 1);
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

  typedef struct packed {
    logic              start;
    logic              term;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [1:0]        state_q, state_d;
  ptr_t              wr_q, wr_d;
  ptr_t              commit_q, commit_d;
  ptr_t              rd_q, rd_d;
  logic              drop_q, drop_d;

  entry_t            mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  entry_t            mem_wdat;
  entry_t            rd_ent;

  logic              full;
  logic              rd_pop;

  // Occupancy includes uncommitted beats, so a frame in progress can fill the store.
  assign full = ((wr_q - rd_q) == PTR_DEPTH);

  assign mem_wdat = {bus.start_i, bus.term_i, bus.len_i, bus.data_i};

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    commit_d  = commit_q;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_q[ADDR_W-1:0];

    if (bus.valid_i) begin
      case (state_q)
        ST_WRITE: begin
          if (bus.cancel_i) begin
            wr_d    = commit_q;
            drop_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (bus.start_i) begin
            // Truncated frame: discard it and restart the new frame at the commit point.
            drop_d    = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = commit_q[ADDR_W-1:0];
            wr_d      = commit_q + PTR_ONE;
            if (bus.term_i) begin
              commit_d = commit_q + PTR_ONE;
              state_d  = ST_IDLE;
            end
          end else if (full) begin
            wr_d    = commit_q;
            drop_d  = 1'b1;
            state_d = ST_DISCARD;
          end else begin
            mem_we = 1'b1;
            wr_d   = wr_q + PTR_ONE;
            if (bus.term_i) begin
              commit_d = wr_q + PTR_ONE;
              state_d  = ST_IDLE;
            end
          end
        end

        default: begin
          // IDLE and DISCARD: wr_q equals commit_q here, so a new frame starts at wr_q.
          if (bus.start_i) begin
            if (bus.cancel_i) begin
              drop_d  = 1'b1;
              state_d = ST_IDLE;
            end else if (full) begin
              drop_d  = 1'b1;
              state_d = ST_DISCARD;
            end else begin
              mem_we = 1'b1;
              wr_d   = wr_q + PTR_ONE;
              if (bus.term_i) begin
                commit_d = wr_q + PTR_ONE;
                state_d  = ST_IDLE;
              end else begin
                state_d = ST_WRITE;
              end
            end
          end else if ((state_q == ST_DISCARD) && (bus.term_i || bus.cancel_i)) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  assign rd_ent      = mem_q[rd_q[ADDR_W-1:0]];
  assign bus.valid_o = (rd_q != commit_q);
  assign bus.start_o = rd_ent.start;
  assign bus.term_o  = rd_ent.term;
  assign bus.data_o  = rd_ent.data;
  assign bus.len_o   = rd_ent.len;
  assign bus.drop_o  = drop_q;

  assign rd_pop = bus.valid_o && bus.ready_i;

  always_comb begin
    rd_d = rd_q;
    if (rd_pop) begin
      rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_q     <= '0;
      commit_q <= '0;
      rd_q     <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      commit_q <= commit_d;
      rd_q     <= rd_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdat;
    end
  end

`ifdef RX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_cnt_clr_i) begin
      drop_cnt_d = '0;
    end else if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
